// File: rtl/dct2_4_pipe.sv
// Three-stage 4-point forward DCT-II row engine (coefficients 64/83/36).
// All stages advance together under a single downstream-driven enable, so one vector is accepted and one emitted per cycle.
module dct2_4_pipe #(
    parameter int IN_W  = 19,
    parameter int SHIFT = 0,
    parameter int OUT_W = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [4*IN_W-1:0]    x_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4*OUT_W-1:0]   y_o,
    output logic                 clip_o
);

    localparam int E_W   = IN_W + 1;
    localparam int ACC_W = IN_W + 8;
    // Compare width is wide enough for both the shifted accumulator and the output range.
    localparam int CW    = ((OUT_W > ACC_W + 1) ? OUT_W : ACC_W + 1) + 1;

    localparam logic signed [ACC_W:0] RND     = ((ACC_W + 1)'(1) <<< SHIFT) >>> 1;
    localparam logic signed [CW-1:0]  SAT_MAX = (CW'(1) <<< (OUT_W - 1)) - CW'(1);
    localparam logic signed [CW-1:0]  SAT_MIN = -(CW'(1) <<< (OUT_W - 1));

    if (IN_W < 2) begin : g_bad_in_w
        $error("dct2_4_pipe: IN_W must be at least 2");
    end
    if (SHIFT < 0 || SHIFT >= IN_W + 8) begin : g_bad_shift
        $error("dct2_4_pipe: SHIFT must lie in [0, IN_W+8)");
    end
    if (OUT_W < 2) begin : g_bad_out_w
        $error("dct2_4_pipe: OUT_W must be at least 2");
    end

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [E_W-1:0] v);
        return {{(ACC_W - E_W){v[E_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] mul83(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul36(input logic signed [ACC_W-1:0] v);
        return (v <<< 5) + (v <<< 2);
    endfunction

    logic                     adv;
    logic signed [E_W-1:0]    xe [4];

    logic                     v1_q, v2_q, v3_q;
    logic signed [E_W-1:0]    e0_q, e1_q, o0_q, o1_q;
    logic signed [E_W-1:0]    e0_d, e1_d, o0_d, o1_d;
    logic signed [ACC_W-1:0]  acc_q [4];
    logic signed [ACC_W-1:0]  acc_d [4];
    logic [4*OUT_W-1:0]       y_q, y_d;
    logic                     clip_q, clip_d;

    logic signed [ACC_W-1:0]  se0, se1, so0, so1;
    logic signed [ACC_W:0]    rnd_s;
    logic signed [CW-1:0]     wide_s;
    logic                     any_sat;

    assign adv         = !v3_q || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = v3_q;
    assign y_o         = y_q;
    assign clip_o      = clip_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xe[i] = {x_i[i*IN_W + IN_W - 1], x_i[i*IN_W +: IN_W]};
        end
        e0_d = xe[0] + xe[3];
        e1_d = xe[1] + xe[2];
        o0_d = xe[0] - xe[3];
        o1_d = xe[1] - xe[2];
    end

    always_comb begin
        se0 = sext(e0_q);
        se1 = sext(e1_q);
        so0 = sext(o0_q);
        so1 = sext(o1_q);
        acc_d[0] = (se0 + se1) <<< 6;
        acc_d[2] = (se0 - se1) <<< 6;
        acc_d[1] = mul83(so0) + mul36(so1);
        acc_d[3] = mul36(so0) - mul83(so1);
    end

    // Rounding add is done one bit wider so the +half cannot wrap before the shift.
    always_comb begin
        y_d     = '0;
        any_sat = 1'b0;
        rnd_s   = '0;
        wide_s  = '0;
        for (int i = 0; i < 4; i++) begin
            rnd_s  = {acc_q[i][ACC_W-1], acc_q[i]} + RND;
            rnd_s  = rnd_s >>> SHIFT;
            wide_s = {{(CW - ACC_W - 1){rnd_s[ACC_W]}}, rnd_s};
            if (wide_s > SAT_MAX) begin
                y_d[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                any_sat = 1'b1;
            end else if (wide_s < SAT_MIN) begin
                y_d[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                any_sat = 1'b1;
            end else begin
                y_d[i*OUT_W +: OUT_W] = wide_s[OUT_W-1:0];
            end
        end
        clip_d = v2_q && any_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            e0_q   <= '0;
            e1_q   <= '0;
            o0_q   <= '0;
            o1_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
            y_q    <= '0;
            clip_q <= 1'b0;
        end else if (adv) begin
            v1_q   <= in_valid_i;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            o0_q   <= o0_d;
            o1_q   <= o1_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
            end
            y_q    <= y_d;
            clip_q <= clip_d;
        end
    end

endmodule

// File: tb/tb_dct2_4_pipe.sv
// Bench for dct2_4_pipe: three parameterisations share one stimulus stream and are
// checked every cycle against a 3-slot occupancy model plus a direct DCT formula.
module tb_dct2_4_pipe;

    localparam int IN_W = 19;
    localparam int XW   = 4 * IN_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [XW-1:0] x;
    logic          out_ready;

    logic          rdyDef, rdyS7, rdyW16;
    logic          ovDef, ovS7, ovW16;
    logic          clipDef, clipS7, clipW16;
    logic [107:0]  yDef, yS7;
    logic [63:0]   yW16;

    dct2_4_pipe dutDef (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdyDef), .x_i(x),
        .out_valid_o(ovDef), .out_ready_i(out_ready), .y_o(yDef), .clip_o(clipDef)
    );

    dct2_4_pipe #(.SHIFT(7)) dutS7 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdyS7), .x_i(x),
        .out_valid_o(ovS7), .out_ready_i(out_ready), .y_o(yS7), .clip_o(clipS7)
    );

    dct2_4_pipe #(.OUT_W(16)) dutW16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdyW16), .x_i(x),
        .out_valid_o(ovW16), .out_ready_i(out_ready), .y_o(yW16), .clip_o(clipW16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            v;
        logic [XW-1:0] x;
    } slot_t;
    slot_t slots [3];

    function automatic logic [XW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [XW-1:0] r;
        r = {d[IN_W-1:0], c[IN_W-1:0], b[IN_W-1:0], a[IN_W-1:0]};
        return r;
    endfunction

    // Direct matrix form of the transform, rounding and clamping in 64-bit arithmetic.
    function automatic void dctModel(input logic [XW-1:0] xv, input int shift, input int outw,
                                     output longint yv [4], output bit clip);
        longint xs [4];
        longint a  [4];
        longint hi, lo, r;
        for (int i = 0; i < 4; i++) xs[i] = longint'($signed(xv[i*IN_W +: IN_W]));
        a[0] = 64 * (xs[0] + xs[1] + xs[2] + xs[3]);
        a[1] = 83 * (xs[0] - xs[3]) + 36 * (xs[1] - xs[2]);
        a[2] = 64 * (xs[0] - xs[1] - xs[2] + xs[3]);
        a[3] = 36 * (xs[0] - xs[3]) - 83 * (xs[1] - xs[2]);
        hi = (longint'(1) <<< (outw - 1)) - 1;
        lo = -hi - 1;
        clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = a[i];
            if (shift > 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
            if (r > hi) begin r = hi; clip = 1'b1; end
            if (r < lo) begin r = lo; clip = 1'b1; end
            yv[i] = r;
        end
    endfunction

    task automatic compareVal(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pinModel(input string name, input logic [XW-1:0] xv, input int shift, input int outw,
                            input longint e0, input longint e1, input longint e2, input longint e3,
                            input bit eclip);
        longint yv [4];
        bit     c;
        dctModel(xv, shift, outw, yv, c);
        compareVal({name, ".y0"}, yv[0], e0);
        compareVal({name, ".y1"}, yv[1], e1);
        compareVal({name, ".y2"}, yv[2], e2);
        compareVal({name, ".y3"}, yv[3], e3);
        compareVal({name, ".clip"}, longint'(c), longint'(eclip));
    endtask

    task automatic checkOutput(input string nm, input int shift, input int ow, input logic ov,
                               input logic rdy, input logic clipv, input logic [107:0] yp);
        longint        yv [4];
        bit            c;
        longint        u;
        logic [107:0]  mask;
        logic          expAdv;
        expAdv = !slots[2].v || out_ready;
        compareVal({nm, ".out_valid"}, longint'(ov), longint'(slots[2].v));
        compareVal({nm, ".in_ready"}, longint'(rdy), longint'(expAdv));
        if (slots[2].v) begin
            dctModel(slots[2].x, shift, ow, yv, c);
            mask = (108'(1) << ow) - 108'(1);
            for (int i = 0; i < 4; i++) begin
                u = longint'((yp >> (i * ow)) & mask);
                if (u[ow-1]) u = u - (longint'(1) <<< ow);
                compareVal($sformatf("%s.y%0d", nm, i), u, yv[i]);
            end
            compareVal({nm, ".clip"}, longint'(clipv), longint'(c));
        end
    endtask

    // Reference occupancy: three slots that all shift when the output is empty or taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) slots[i].v = 1'b0;
            compareVal("rst.def.out_valid", longint'(ovDef), 0);
            compareVal("rst.s7.out_valid", longint'(ovS7), 0);
            compareVal("rst.w16.out_valid", longint'(ovW16), 0);
            compareVal("rst.def.clip", longint'(clipDef), 0);
            compareVal("rst.def.y", longint'(yDef[63:0]), 0);
        end else begin
            checkOutput("def", 0, 27, ovDef, rdyDef, clipDef, yDef);
            checkOutput("s7", 7, 27, ovS7, rdyS7, clipS7, yS7);
            checkOutput("w16", 0, 16, ovW16, rdyW16, clipW16, {44'b0, yW16});
            if (!slots[2].v || out_ready) begin
                slots[2] = slots[1];
                slots[1] = slots[0];
                slots[0].v = in_valid;
                slots[0].x = x;
            end
        end
    end

    task automatic applyStimulus(input logic [XW-1:0] xv, input logic valid, input logic ready);
        @(posedge clk);
        #1;
        x         = xv;
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b1);
    endtask

    initial begin
        int sent;
        int guard;
        logic [XW-1:0] rv;
        for (int i = 0; i < 3; i++) begin
            slots[i].v = 1'b0;
            slots[i].x = '0;
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;

        // Hand-derived values; {1,2,3,4} gives O0=-3, O1=-1 so Y1=-249-36, Y3=-108+83.
        pinModel("pin.impulse", pack4(100, 0, 0, 0), 0, 27, 6400, 8300, 6400, 3600, 0);
        pinModel("pin.s7pos", pack4(100, 0, 0, 0), 7, 27, 50, 65, 50, 28, 0);
        pinModel("pin.s7neg", pack4(-100, 0, 0, 0), 7, 27, -50, -65, -50, -28, 0);
        pinModel("pin.dc", pack4(1000, 1000, 1000, 1000), 0, 27, 256000, 0, 0, 0, 0);
        pinModel("pin.ramp", pack4(1, 2, 3, 4), 0, 27, 640, -285, 0, -25, 0);
        pinModel("pin.satpos", pack4(262143, 262143, 262143, 262143), 0, 16, 32767, 0, 0, 0, 1);
        pinModel("pin.satneg", pack4(-262144, 0, 0, 0), 0, 16, -32768, -32768, -32768, -32768, 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(pack4(100, 0, 0, 0), 1'b1, 1'b1);
        idle(4);
        applyStimulus(pack4(-100, 0, 0, 0), 1'b1, 1'b1);
        idle(4);
        applyStimulus(pack4(1000, 1000, 1000, 1000), 1'b1, 1'b1);
        applyStimulus(pack4(1, 2, 3, 4), 1'b1, 1'b1);
        applyStimulus(pack4(262143, 262143, 262143, 262143), 1'b1, 1'b1);
        applyStimulus(pack4(-262144, 0, 0, 0), 1'b1, 1'b1);
        applyStimulus(pack4(-262144, 262143, -262144, 262143), 1'b1, 1'b1);
        idle(5);

        sent  = 0;
        guard = 0;
        rv    = pack4($urandom_range(0, 524287), $urandom_range(0, 524287),
                      $urandom_range(0, 524287), $urandom_range(0, 524287));
        while (sent < 8 && guard < 300) begin
            applyStimulus(rv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (in_valid && rdyDef) begin
                sent++;
                rv = pack4($urandom_range(0, 524287), $urandom_range(0, 524287),
                           $urandom_range(0, 524287), $urandom_range(0, 524287));
            end
            guard++;
        end
        compareVal("stream.accepted", longint'(sent), 8);
        idle(6);

        applyStimulus(pack4(5, -7, 9, -11), 1'b1, 1'b1);
        applyStimulus(pack4(300, 200, 100, 0), 1'b1, 1'b1);
        applyStimulus(pack4(-1, -1, -1, -1), 1'b1, 1'b1);
        applyStimulus('0, 1'b0, 1'b1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        applyStimulus(pack4(7, 0, 0, -7), 1'b1, 1'b1);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
